// File: rtl/hs4_pkg.sv
// Shared types and defaults for the 4-phase bundled-data receive endpoint.
package hs4_pkg;

  // Handshake FSM: IDLE waits for a request, ACK holds the acknowledge high
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEPTH       = 4;

  // Occupancy counter width: one extra bit so a full FIFO (count == depth) fits
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs4_fifo.sv
// Small first-word fall-through FIFO between the handshake endpoint and the
// clocked consumer. Pushes are refused on the current full state even when a
// pop occurs in the same cycle; an empty FIFO presents zero on its data port.
module hs4_fifo
  import hs4_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = cnt_w(DEPTH),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  // Storage array: data only, never reset (contents are masked while empty)
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks push/pop balance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hs4_rx_sync.sv
// Clocked receiving endpoint of a 4-phase req/ack bundled-data channel.
// The asynchronous request is synchronized, the bundled word is captured into
// a FIFO while the acknowledge is raised, and the FIFO is drained by the
// clocked fabric through a valid/ready stream. A full FIFO back-pressures the
// sender by withholding the acknowledge.
module hs4_rx_sync
  import hs4_pkg::*;
#(
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int DEPTH       = DEF_DEPTH,
  localparam int CNT_W       = cnt_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              err_o
);

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   req_s_q;
  state_t                 state;
  state_t                 state_nx;
  logic                   push;
  logic                   ack_q;
  logic                   err_q;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign req_s = req_sync[SYNC_STAGES-1];

  // Synchronizer chain: the only reader of the asynchronous request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
    end
  end

  // Handshake decision: capture on a synchronized request if there is room
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !fifo_full) begin
          push     = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM, registered acknowledge and sticky withdrawn-request detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      req_s_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ack_q   <= (state_nx == ACK);
      req_s_q <= req_s;
      if ((state == IDLE) && req_s_q && !req_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign out_valid_o = !fifo_empty;

  hs4_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (out_ready_i),
    .data_o  (out_data_o),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
